// File: rtl/cmd_pkg.sv
// ============================================================================
// Module      : cmd_pkg
// Description : Shared constants, type codes and FSM states for the host
//               command link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_pkg;

    localparam logic [7:0] c_HEAD          = 8'h55;

    localparam logic [7:0] c_TYPE_ADC_CFG  = 8'h01;
    localparam logic [7:0] c_TYPE_IIC_WR   = 8'h02;
    localparam logic [7:0] c_TYPE_SPI_WR   = 8'h03;
    localparam logic [7:0] c_TYPE_IIC_RD   = 8'h04;
    localparam logic [7:0] c_TYPE_ADC_READ = 8'h05;

    localparam logic [1:0] c_ERR_NONE      = 2'b00;
    localparam logic [1:0] c_ERR_BAD_TYPE  = 2'b01;
    localparam logic [1:0] c_ERR_BAD_LEN   = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TYPE = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // A value in 1..max is legal for both TYPE and LEN.
    function automatic logic in_range(input logic [7:0] value, input logic [7:0] max);
        return (value != 8'd0) && (value <= max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_frame_parser_if.sv
// ============================================================================
// Module      : cmd_frame_parser_if
// Description : Byte input and decoded payload / error output bundle of the
//               command frame parser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmd_frame_parser_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd_type;
    logic [7:0] cmd_len;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_last;
    logic       frame_err;
    logic [1:0] err_code;

    // Byte source / payload sink side.
    modport master (
        output rx_data, rx_valid,
        input  cmd_type, cmd_len, cmd_data, cmd_valid, cmd_last, frame_err, err_code
    );

    // Parser side.
    modport slave (
        input  rx_data, rx_valid,
        output cmd_type, cmd_len, cmd_data, cmd_valid, cmd_last, frame_err, err_code
    );

endinterface

`default_nettype wire

// File: rtl/cmd_timeout_cnt.sv
// ============================================================================
// Module      : cmd_timeout_cnt
// Description : Inactivity counter with clear / enable and a one-cycle expire
//               strobe when the count reaches P_TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_timeout_cnt #(
    parameter int P_TIMEOUT = 50_000
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);

    localparam int              c_W     = $clog2(P_TIMEOUT);
    localparam logic [c_W-1:0]  c_LIMIT = c_W'(P_TIMEOUT - 1);

    logic [c_W-1:0] r_cnt;

    // Expiry ignores i_clear so a byte landing on the expiry cycle cannot mask it.
    assign o_expire = i_enable && (r_cnt == c_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cmd_frame_parser.sv
// ============================================================================
// Module      : cmd_frame_parser
// Description : Decodes {HEAD, TYPE, LEN, DATA[LEN]} host frames from the UART
//               byte stream into a payload beat stream with error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter logic [7:0] P_HEAD     = c_HEAD,
    parameter int         P_TYPE_MAX = 5,
    parameter int         P_MAX_LEN  = 16,
    parameter int         P_TIMEOUT  = 50_000
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    cmd_frame_parser_if.slave bus
);

    localparam logic [7:0] c_TYPE_MAX = 8'(P_TYPE_MAX);
    localparam logic [7:0] c_MAX_LEN  = 8'(P_MAX_LEN);

    state_t     r_state,     w_state_nxt;
    logic [7:0] r_remaining, w_remaining_nxt;
    logic       r_bad_type,  w_bad_type_nxt;
    logic [7:0] r_cmd_type,  w_cmd_type_nxt;
    logic [7:0] r_cmd_len,   w_cmd_len_nxt;
    logic [7:0] r_cmd_data,  w_cmd_data_nxt;
    logic       r_cmd_valid, w_cmd_valid_nxt;
    logic       r_cmd_last,  w_cmd_last_nxt;
    logic       r_frame_err, w_frame_err_nxt;
    logic [1:0] r_err_code,  w_err_code_nxt;
    logic       w_expire;

    cmd_timeout_cnt #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (bus.rx_valid || (r_state == ST_IDLE)),
        .i_enable (r_state != ST_IDLE),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_bad_type_nxt  = r_bad_type;
        w_cmd_type_nxt  = r_cmd_type;
        w_cmd_len_nxt   = r_cmd_len;
        w_cmd_data_nxt  = r_cmd_data;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_last_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;

        if (w_expire) begin
            // Abort the frame; a coincident byte is treated as if seen in IDLE.
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = c_ERR_TIMEOUT;
            w_state_nxt     = (bus.rx_valid && (bus.rx_data == P_HEAD)) ? ST_TYPE : ST_IDLE;
        end else if (bus.rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_data == P_HEAD) begin
                        w_state_nxt = ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    w_cmd_type_nxt = bus.rx_data;
                    w_bad_type_nxt = !in_range(bus.rx_data, c_TYPE_MAX);
                    w_state_nxt    = ST_LEN;
                end
                ST_LEN: begin
                    w_cmd_len_nxt = bus.rx_data;
                    // A bad LEN is reported even when TYPE was also bad.
                    if (!in_range(bus.rx_data, c_MAX_LEN)) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = c_ERR_BAD_LEN;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_remaining_nxt = bus.rx_data;
                        w_state_nxt     = r_bad_type ? ST_DROP : ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_cmd_data_nxt  = bus.rx_data;
                    w_cmd_valid_nxt = 1'b1;
                    w_remaining_nxt = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_cmd_last_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    w_remaining_nxt = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = c_ERR_BAD_TYPE;
                        w_state_nxt     = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 8'd0;
            r_bad_type  <= 1'b0;
            r_cmd_type  <= 8'd0;
            r_cmd_len   <= 8'd0;
            r_cmd_data  <= 8'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_last  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_bad_type  <= w_bad_type_nxt;
            r_cmd_type  <= w_cmd_type_nxt;
            r_cmd_len   <= w_cmd_len_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_last  <= w_cmd_last_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    assign bus.cmd_type  = r_cmd_type;
    assign bus.cmd_len   = r_cmd_len;
    assign bus.cmd_data  = r_cmd_data;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_last  = r_cmd_last;
    assign bus.frame_err = r_frame_err;
    assign bus.err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_parser.sv
// ============================================================================
// Module      : tb_cmd_frame_parser
// Description : Directed frames with a queued scoreboard for payload beats
//               and error strobes, checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_frame_parser;
    import cmd_pkg::*;

    localparam int c_T = 64;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] typ;
        logic [7:0] len;
        int         cyc;
    } beat_t;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } err_t;

    logic  clk;
    logic  rst_n;
    int    cyc;
    int    checks;
    int    errors;
    int    last_cyc;
    int    save_cyc;
    beat_t beat_q[$];
    err_t  err_q[$];
    beat_t m_beat;
    err_t  m_err;

    cmd_frame_parser_if bus ();

    cmd_frame_parser #(
        .P_HEAD     (8'h55),
        .P_TYPE_MAX (5),
        .P_MAX_LEN  (16),
        .P_TIMEOUT  (c_T)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every DUT output event must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid) begin
                checks++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat data=%h last=%b cyc=%0d", bus.cmd_data, bus.cmd_last, cyc);
                end else begin
                    m_beat = beat_q.pop_front();
                    if (bus.cmd_data !== m_beat.data || bus.cmd_last !== m_beat.last ||
                        bus.cmd_type !== m_beat.typ || bus.cmd_len !== m_beat.len || cyc != m_beat.cyc) begin
                        errors++;
                        $display("FAIL beat got data=%h last=%b type=%h len=%h cyc=%0d exp data=%h last=%b type=%h len=%h cyc=%0d",
                                 bus.cmd_data, bus.cmd_last, bus.cmd_type, bus.cmd_len, cyc,
                                 m_beat.data, m_beat.last, m_beat.typ, m_beat.len, m_beat.cyc);
                    end
                end
            end else if (bus.cmd_last) begin
                checks++;
                errors++;
                $display("FAIL stray_last cmd_last=1 without cmd_valid cyc=%0d", cyc);
            end
            if (bus.frame_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err code=%b cyc=%0d", bus.err_code, cyc);
                end else begin
                    m_err = err_q.pop_front();
                    if (bus.err_code !== m_err.code || cyc != m_err.cyc) begin
                        errors++;
                        $display("FAIL err got code=%b cyc=%0d exp code=%b cyc=%0d",
                                 bus.err_code, cyc, m_err.code, m_err.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_type"},  bus.cmd_type, 8'h00);
        chk({tag, "_len"},   bus.cmd_len, 8'h00);
        chk({tag, "_data"},  bus.cmd_data, 8'h00);
        chk({tag, "_valid"}, {7'd0, bus.cmd_valid}, 8'h00);
        chk({tag, "_last"},  {7'd0, bus.cmd_last}, 8'h00);
        chk({tag, "_err"},   {7'd0, bus.frame_err}, 8'h00);
        chk({tag, "_code"},  {6'd0, bus.err_code}, 8'h00);
    endtask

    // Called at posedge+1; drives one byte for exactly one sampling edge.
    task automatic send(input logic [7:0] b);
        last_cyc     = cyc + 1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] b, input logic last, input logic [7:0] typ, input logic [7:0] len);
        beat_q.push_back('{data: b, last: last, typ: typ, len: len, cyc: cyc + 1});
        send(b);
    endtask

    task automatic send_err(input logic [7:0] b, input logic [1:0] code);
        err_q.push_back('{code: code, cyc: cyc + 1});
        send(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_basic();
        send(8'h55); send(c_TYPE_ADC_READ); send(8'h01);
        send_beat(8'h01, 1'b1, 8'h05, 8'h01);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        last_cyc     = 0;
        save_cyc     = 0;
        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Single-byte frame, then a frame with an embedded head value.
        frame_basic();
        send(8'h55); send(c_TYPE_SPI_WR); send(8'h04);
        send_beat(8'hAA, 1'b0, 8'h03, 8'h04);
        send_beat(8'h55, 1'b0, 8'h03, 8'h04);
        send_beat(8'hBB, 1'b0, 8'h03, 8'h04);
        send_beat(8'hCC, 1'b1, 8'h03, 8'h04);

        // Leading garbage is ignored.
        send(8'h12); send(8'h34);
        frame_basic();

        // Illegal TYPE: payload dropped, error after last byte, then recovery.
        send(8'h55); send(8'h09); send(8'h02); send(8'h11);
        send_err(8'h22, c_ERR_BAD_TYPE);
        frame_basic();

        // Illegal LEN (0 and 17); following byte is ignored in IDLE.
        send(8'h55); send(8'h05); send_err(8'h00, c_ERR_BAD_LEN); send(8'h01);
        send(8'h55); send(8'h05); send_err(8'h11, c_ERR_BAD_LEN); send(8'h01);

        // Bad TYPE together with bad LEN reports LEN; TYPE 0 and 6 are illegal.
        send(8'h55); send(8'h00); send_err(8'h00, c_ERR_BAD_LEN);
        send(8'h55); send(8'h06); send(8'h01); send_err(8'hAB, c_ERR_BAD_TYPE);

        // Maximum LEN of 16.
        send(8'h55); send(c_TYPE_IIC_WR); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_beat(8'hA0 + 8'(i), (i == 15), 8'h02, 8'h10);
        end

        // Stall after first of three payload bytes.
        send(8'h55); send(8'h05); send(8'h03);
        send_beat(8'h01, 1'b0, 8'h05, 8'h03);
        err_q.push_back('{code: c_ERR_TIMEOUT, cyc: last_cyc + c_T});
        idle(c_T + 4);

        // Head byte arriving on the expiry cycle starts a new frame.
        send(8'h55); send(8'h04); send(8'h02);
        save_cyc = last_cyc;
        idle(c_T - 1);
        err_q.push_back('{code: c_ERR_TIMEOUT, cyc: save_cyc + c_T});
        send(8'h55);
        send(8'h05); send(8'h01);
        send_beat(8'h01, 1'b1, 8'h05, 8'h01);
        idle(3);

        // Asynchronous reset in the middle of a frame.
        send(8'h55); send(8'h05); send(8'h03);
        send_beat(8'h01, 1'b0, 8'h05, 8'h03);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        frame_basic();

        // Drain with a bounded wait.
        for (int i = 0; i < 200 && (beat_q.size() != 0 || err_q.size() != 0); i++) begin
            @(posedge clk);
        end
        idle(2);
        chk("beats_outstanding", 8'(beat_q.size()), 8'd0);
        chk("errs_outstanding", 8'(err_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
